fabric_config_loader: RTL
=========================

Name: fabric_config_loader

Overview:
Bitstream transmitter for the eFPGA configuration port. Accepts 32-bit configuration words over a valid/ready stream and drives the frame data shift interface (fd_shift, fd_data) and the row-strobe counter interface (rs_reset, rs_incr, rs_strobe) that load the fabric frame by frame. Sits on-chip next to the wrapper, fed from the management side. Its outputs drive the same pins/nets the wrapper's frame data register and strobe counter sample on the same clock.

Parameters:
NumberOfRows, 6, fabric rows; frame length = NumberOfRows*FrameBitsPerRow bits
FrameBitsPerRow, 32, frame bits per row
NumberOfCols, 8, fabric columns
MaxFramesPerCol, 36, frames per column; total frames = NumberOfCols*MaxFramesPerCol (288)

Ports:
wb_clk_i  input  1  clock; also the clock of the downstream frame register and strobe counter
wb_rst_i  input  1  synchronous, active-high reset
start  input  1  begin a full bitstream load; sampled only in IDLE or DONE
word_valid  input  1  word_data holds a valid word
word_data  input  32  configuration word
word_ready  output  1  word accepted when word_valid && word_ready
fd_shift  output  1  frame data shift enable
fd_data  output  1  serial frame data bit
rs_reset  output  1  clear downstream strobe counter
rs_incr  output  1  advance downstream strobe counter
rs_strobe  output  1  write frame register into the selected frame
busy  output  1  load in progress
done  output  1  high in DONE until next start or reset
frame_count  output  16  frames written since start

Behaviour:
- All outputs driven directly from flops (glitch-free pins). Reset: every output 0, state IDLE, internal counters 0. Reset wins over all other inputs in any state.
- WORDS_PER_FRAME = NumberOfRows (FrameBitsPerRow = 32 = word width). TOTAL_FRAMES = NumberOfCols*MaxFramesPerCol.
- States: IDLE, CLR, WAIT, SHIFT, STROBE, INCR, DONE.
- IDLE/DONE: start=1 -> CLR; frame_count, word index cleared; done=0. start outside IDLE/DONE is ignored.
- CLR: rs_reset=1 for exactly one cycle, busy=1 -> WAIT.
- WAIT: word_ready=1. On handshake, capture word into a 32-bit shift register -> SHIFT. No handshake: stay, fd_shift=0, no bits lost.
- SHIFT: 32 consecutive cycles fd_shift=1, fd_data = captured bit 0,1,...,31 (LSB first). word_ready=0. After 32nd bit: if word index < WORDS_PER_FRAME-1, increment index -> WAIT; else clear index -> STROBE.
- Bit order: first word of a frame carries frame bits [31:0], word k carries [32k+31:32k]; after 192 shifts the downstream right-shifting register holds the frame with first transmitted bit at bit 0.
- STROBE: rs_strobe=1 one cycle, fd_shift=0, rs_incr=0 (counter stable during strobe).
- INCR: rs_incr=1 one cycle, frame_count+1. If frame_count was TOTAL_FRAMES-1 -> DONE (busy=0, done=1), else -> WAIT.
- rs_reset, rs_incr, rs_strobe, fd_shift mutually exclusive every cycle.
- Per-frame minimum latency: 6*(1+32)+2 = 200 cycles; full load with word_valid held high: 1 + 288*200 = 57601 cycles from start-sample to done.
- fd_data is 0 whenever fd_shift=0.

Test Plan:
1. Assert wb_rst_i 2 cycles with start=1, word_valid=1 -> all outputs 0, word_ready 0, remains IDLE after release until start.
2. start pulse -> next cycle rs_reset=1 for one cycle only, then word_ready=1; word 0x8000_0001 -> fd_shift high 32 cycles, fd_data = 1, thirty 0s, 1.
3. Feed 6 words -> exactly one rs_strobe cycle with fd_shift=0, then one rs_incr cycle, frame_count=1, word_ready returns.
4. Full 1728-word random bitstream, valid always high, bench model of wrapper shift register + strobe counter -> all 288 captured frames equal source, done after 57601 cycles, busy 0.
5. Deassert word_valid 10 cycles mid-frame, start pulses while busy -> no fd_shift, no restart, frame contents unchanged vs model.
6. wb_rst_i during SHIFT of frame 5 -> outputs 0 next cycle; new start -> rs_reset issued, frame_count restarts at 0, full load correct.

Source files
------------

// File: rtl/fabric_config_loader.sv
// fabric_config_loader: streams 32-bit configuration words into the eFPGA
// frame data shift register (LSB first) and sequences the row-strobe counter
// so every frame of the fabric is written once per load.
// Every output is a flop. The next-state logic computes the value each output
// must have in the state being entered, so pins change only on clock edges.
module fabric_config_loader #(
    parameter int NumberOfRows    = 6,
    parameter int FrameBitsPerRow = 32,
    parameter int NumberOfCols    = 8,
    parameter int MaxFramesPerCol = 36
) (
    input  logic                       wb_clk_i,
    input  logic                       wb_rst_i,
    input  logic                       start,
    input  logic                       word_valid,
    input  logic [FrameBitsPerRow-1:0] word_data,
    output logic                       word_ready,
    output logic                       fd_shift,
    output logic                       fd_data,
    output logic                       rs_reset,
    output logic                       rs_incr,
    output logic                       rs_strobe,
    output logic                       busy,
    output logic                       done,
    output logic [15:0]                frame_count
);

    // One configuration word fills one row slice of the frame.
    localparam int WORDS_PER_FRAME = NumberOfRows;
    localparam int TOTAL_FRAMES    = NumberOfCols * MaxFramesPerCol;
    localparam int WIDX_W          = (WORDS_PER_FRAME > 1) ? $clog2(WORDS_PER_FRAME) : 1;
    localparam int BIT_W           = (FrameBitsPerRow > 1) ? $clog2(FrameBitsPerRow) : 1;

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        WAIT,
        SHIFT,
        STROBE,
        INCR,
        DONE
    } state_t;

    state_t                     state_q, state_d;
    logic [FrameBitsPerRow-1:0] shreg_q, shreg_d;   // bits still to be sent
    logic [BIT_W-1:0]           bit_q, bit_d;       // index of bit on fd_data
    logic [WIDX_W-1:0]          widx_q, widx_d;     // word index within frame
    logic [15:0]                fc_d;

    logic word_ready_d, fd_shift_d, fd_data_d;
    logic rs_reset_d, rs_incr_d, rs_strobe_d, busy_d, done_d;

    // Next-state and next-output decode; outputs describe the entered state.
    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        bit_d        = bit_q;
        widx_d       = widx_q;
        fc_d         = frame_count;
        word_ready_d = 1'b0;
        fd_shift_d   = 1'b0;
        fd_data_d    = 1'b0;
        rs_reset_d   = 1'b0;
        rs_incr_d    = 1'b0;
        rs_strobe_d  = 1'b0;
        busy_d       = 1'b1;
        done_d       = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                busy_d = 1'b0;
                done_d = (state_q == DONE);
                if (start) begin
                    state_d    = CLR;
                    fc_d       = '0;
                    widx_d     = '0;
                    bit_d      = '0;
                    rs_reset_d = 1'b1;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                end
            end

            CLR: begin
                state_d      = WAIT;
                word_ready_d = 1'b1;
            end

            // Hold ready until a word arrives; stalls emit nothing.
            WAIT: begin
                if (word_valid && word_ready) begin
                    state_d    = SHIFT;
                    shreg_d    = word_data >> 1;
                    bit_d      = '0;
                    fd_shift_d = 1'b1;
                    fd_data_d  = word_data[0];
                end else begin
                    word_ready_d = 1'b1;
                end
            end

            SHIFT: begin
                if (bit_q == BIT_W'(FrameBitsPerRow - 1)) begin
                    if (widx_q < WIDX_W'(WORDS_PER_FRAME - 1)) begin
                        widx_d       = widx_q + 1'b1;
                        state_d      = WAIT;
                        word_ready_d = 1'b1;
                    end else begin
                        widx_d      = '0;
                        state_d     = STROBE;
                        rs_strobe_d = 1'b1;
                    end
                end else begin
                    bit_d      = bit_q + 1'b1;
                    shreg_d    = shreg_q >> 1;
                    fd_shift_d = 1'b1;
                    fd_data_d  = shreg_q[0];
                end
            end

            // Counter is held still while the frame is written.
            STROBE: begin
                state_d   = INCR;
                rs_incr_d = 1'b1;
            end

            INCR: begin
                fc_d = frame_count + 16'd1;
                if (frame_count == 16'(TOTAL_FRAMES - 1)) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    state_d      = WAIT;
                    word_ready_d = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State, datapath and output registers; reset overrides everything.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            bit_q       <= '0;
            widx_q      <= '0;
            frame_count <= '0;
            word_ready  <= 1'b0;
            fd_shift    <= 1'b0;
            fd_data     <= 1'b0;
            rs_reset    <= 1'b0;
            rs_incr     <= 1'b0;
            rs_strobe   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            bit_q       <= bit_d;
            widx_q      <= widx_d;
            frame_count <= fc_d;
            word_ready  <= word_ready_d;
            fd_shift    <= fd_shift_d;
            fd_data     <= fd_data_d;
            rs_reset    <= rs_reset_d;
            rs_incr     <= rs_incr_d;
            rs_strobe   <= rs_strobe_d;
            busy        <= busy_d;
            done        <= done_d;
        end
    end

    // The downstream strobe counter and frame register must never see two
    // commands in one cycle, and serial data is quiet outside shifting.
    a_cmd_exclusive: assert property (@(posedge wb_clk_i) disable iff (wb_rst_i)
        $onehot0({rs_reset, rs_incr, rs_strobe, fd_shift}));
    a_data_quiet: assert property (@(posedge wb_clk_i) disable iff (wb_rst_i)
        !fd_shift |-> !fd_data);

endmodule
